// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file writeback path
package regfile_pkg;
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;
  localparam int NUM_REGS = 32;
  localparam int REG_ZERO = 0;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_write_arbiter_wb_slot.sv
// wb_slot: one-entry writeback holding buffer; clear frees it and may refill on the same edge
module wb_slot #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear,
  output logic              ready,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  assign ready = !full || clear;
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else if (valid && ready) begin
      full <= 1'b1;
      addr <= wr_addr;
      data <= wr_data;
    end else if (clear) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between ALU and load writeback.
// Define RFWB_RR_ARB_EN for round-robin on different-address contention (default: MEM > ALU).
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                in_clk,
  input  logic                in_reset,
  input  logic                in_alu_valid,
  input  logic [ADDR_W-1:0]   in_alu_addr,
  input  logic [DATA_W-1:0]   in_alu_data,
  output logic                out_alu_ready,
  input  logic                in_mem_valid,
  input  logic [ADDR_W-1:0]   in_mem_addr,
  input  logic [DATA_W-1:0]   in_mem_data,
  output logic                out_mem_ready,
  output logic [DATA_W-1:0]   out_PC,
  output logic [ADDR_W-1:0]   out_SC,
  output logic                out_RFL,
  output logic [NUM_REGS-1:0] out_pending,
  output logic [CNT_W-1:0]    out_stall_cnt
);
  logic a_full, m_full, a_gnt, m_gnt, m_acc, alu_older, mem_wins, wr, stall;
  logic [ADDR_W-1:0] a_addr, m_addr, w_addr;
  logic [DATA_W-1:0] a_data, m_data, w_data;
  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu (
    .clk(in_clk), .rst(in_reset), .valid(in_alu_valid), .wr_addr(in_alu_addr),
    .wr_data(in_alu_data), .clear(a_gnt), .ready(out_alu_ready), .full(a_full),
    .addr(a_addr), .data(a_data)
  );
  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk(in_clk), .rst(in_reset), .valid(in_mem_valid), .wr_addr(in_mem_addr),
    .wr_data(in_mem_data), .clear(m_gnt), .ready(out_mem_ready), .full(m_full),
    .addr(m_addr), .data(m_data)
  );
`ifdef RFWB_RR_ARB_EN
  logic rr_ptr;
  assign mem_wins = rr_ptr == REQ_ALU;
  always_ff @(posedge in_clk) begin
    if (in_reset) rr_ptr <= REQ_ALU;
    else if (a_full && m_full && a_addr != m_addr) rr_ptr <= ~rr_ptr;
  end
`else
  assign mem_wins = 1'b1;
`endif
  // same-address pairs must retire in acceptance order so the younger value lands last
  assign m_gnt  = m_full && (!a_full || (a_addr == m_addr ? !alu_older : mem_wins));
  assign a_gnt  = a_full && !m_gnt;
  assign m_acc  = in_mem_valid && out_mem_ready;
  assign w_addr = m_gnt ? m_addr : a_addr;
  assign w_data = m_gnt ? m_data : a_data;
  assign wr     = (a_gnt || m_gnt) && w_addr != ADDR_W'(REG_ZERO);
  assign stall  = (in_alu_valid && !out_alu_ready) || (in_mem_valid && !out_mem_ready);
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      out_PC        <= '0;
      out_SC        <= '0;
      out_RFL       <= 1'b0;
      out_stall_cnt <= '0;
      alu_older     <= 1'b0;
    end else begin
      out_RFL   <= wr;
      alu_older <= a_full && !a_gnt && m_acc;
      if (wr) begin
        out_PC <= w_data;
        out_SC <= w_addr;
      end
      if (stall && out_stall_cnt != '1) out_stall_cnt <= out_stall_cnt + CNT_W'(1);
    end
  end
  always_comb begin
    out_pending = '0;
    if (a_full) out_pending[a_addr] = 1'b1;
    if (m_full) out_pending[m_addr] = 1'b1;
    if (out_RFL) out_pending[out_SC] = 1'b1;
    out_pending[REG_ZERO] = 1'b0;
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of arbitration, R0 drop, pending, stall and reset
module tb_regfile_write_arbiter;
  logic clk = 1'b0, rst, av, mv, a_rdy, m_rdy, rfl;
  logic [4:0] aa, ma, sc;
  logic [31:0] ad, md, pc, pend;
  logic [15:0] stall;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  regfile_write_arbiter dut (
    .in_clk(clk), .in_reset(rst),
    .in_alu_valid(av), .in_alu_addr(aa), .in_alu_data(ad), .out_alu_ready(a_rdy),
    .in_mem_valid(mv), .in_mem_addr(ma), .in_mem_data(md), .out_mem_ready(m_rdy),
    .out_PC(pc), .out_SC(sc), .out_RFL(rfl), .out_pending(pend), .out_stall_cnt(stall)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; av = 0; mv = 0; aa = 0; ad = 0; ma = 0; md = 0;
    tick; tick;
    chk("rst_rfl", rfl, 0); chk("rst_pc", pc, 0); chk("rst_sc", sc, 0);
    chk("rst_pend", pend, 0); chk("rst_stall", stall, 0);
    chk("rst_ardy", a_rdy, 1); chk("rst_mrdy", m_rdy, 1);
    rst = 0;
    // single ALU write
    av = 1; aa = 4; ad = 32'h4;
    chk("t1_ardy", a_rdy, 1);
    tick; av = 0;
    chk("t1_rfl0", rfl, 0); chk("t1_pend_slot", pend, 32'h10);
    tick;
    chk("t1_rfl", rfl, 1); chk("t1_sc", sc, 4); chk("t1_pc", pc, 32'h4); chk("t1_pend_port", pend, 32'h10);
    tick;
    chk("t1_rfl_off", rfl, 0); chk("t1_pend_clr", pend, 0);
    // contested different addresses: MEM first, ALU stalls one cycle
    av = 1; aa = 3; ad = 32'hFFFFFFFF; mv = 1; ma = 5; md = 32'h12345678;
    tick; aa = 9; ad = 32'h99; mv = 0;
    chk("t2_ardy", a_rdy, 0); chk("t2_mrdy", m_rdy, 1); chk("t2_stall0", stall, 0); chk("t2_pend", pend, 32'h28);
    tick;
    chk("t2_sc_mem", sc, 5); chk("t2_pc_mem", pc, 32'h12345678); chk("t2_stall1", stall, 1); chk("t2_ardy1", a_rdy, 1);
    tick; av = 0;
    chk("t2_sc_alu", sc, 3); chk("t2_pc_alu", pc, 32'hFFFFFFFF); chk("t2_stall_hold", stall, 1); chk("t2_pend2", pend, 32'h208);
    tick;
    chk("t2_sc_9", sc, 9); chk("t2_pc_9", pc, 32'h99);
    tick;
    chk("t2_idle", rfl, 0);
    // same address, same cycle: MEM older, ALU value persists
    av = 1; aa = 7; ad = 32'hAAAA; mv = 1; ma = 7; md = 32'hBBBB;
    tick; av = 0; mv = 0;
    chk("t3_pend", pend, 32'h80); chk("t3_ardy", a_rdy, 0);
    tick;
    chk("t3_sc_first", sc, 7); chk("t3_pc_first", pc, 32'hBBBB);
    tick;
    chk("t3_rfl_second", rfl, 1); chk("t3_pc_second", pc, 32'hAAAA);
    tick;
    // write to R0 is dropped
    av = 1; aa = 0; ad = 32'hDEADBEEF;
    tick; av = 0;
    chk("t4_pend", pend, 0); chk("t4_rfl0", rfl, 0); chk("t4_ardy", a_rdy, 1);
    tick;
    chk("t4_rfl", rfl, 0); chk("t4_pend2", pend, 0); chk("t4_pc_hold", pc, 32'hAAAA); chk("t4_sc_hold", sc, 7);
    // age: ALU held while a younger MEM write to the same register arrives
    rst = 1; tick; rst = 0;
    av = 1; aa = 10; ad = 32'hA1; mv = 1; ma = 11; md = 32'hB1;
    tick; av = 0; ma = 10; md = 32'hB2;
    chk("age_mrdy", m_rdy, 1);
    tick; mv = 0;
    chk("age_sc1", sc, 11); chk("age_pc1", pc, 32'hB1); chk("age_mrdy0", m_rdy, 0);
    tick;
    chk("age_sc2", sc, 10); chk("age_pc2", pc, 32'hA1);
    tick;
    chk("age_sc3", sc, 10); chk("age_pc3", pc, 32'hB2);
    tick;
    // back-to-back ALU stream
    rst = 1; tick; rst = 0;
    for (int i = 1; i <= 8; i++) begin
      av = 1; aa = 5'(i); ad = 32'h100 + 32'(i);
      chk("t5_ardy", a_rdy, 1);
      tick;
      if (i > 1) chk("t5_sc", sc, 64'(i - 1));
    end
    av = 0;
    tick;
    chk("t5_sc_last", sc, 8); chk("t5_pc_last", pc, 32'h108); chk("t5_rfl_last", rfl, 1); chk("t5_stall", stall, 0);
    tick;
    // reset with both slots full discards everything
    av = 1; aa = 12; ad = 32'hC; mv = 1; ma = 13; md = 32'hD;
    tick; av = 0; mv = 0; rst = 1;
    chk("t6_ardy_full", a_rdy, 0);
    tick; rst = 0;
    chk("t6_rfl", rfl, 0); chk("t6_pend", pend, 0); chk("t6_ardy", a_rdy, 1); chk("t6_mrdy", m_rdy, 1);
    tick;
    chk("t6_rfl_after", rfl, 0);
`ifdef RFWB_RR_ARB_EN
    for (int r = 0; r < 3; r++) begin
      av = 1; aa = 20; ad = 32'(r); mv = 1; ma = 21; md = 32'(r);
      tick; av = 0; mv = 0;
      tick;
      chk("rr_first", sc, r == 1 ? 20 : 21);
      tick; tick;
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
